// File: rtl/bt_cmd_parser.sv
// Frame parser for the Bluetooth UART byte stream: {HEADER, CMD, ARG, CMD^ARG}.
// Publishes validated CMD/ARG and flags checksum and inter-byte timeout failures.
module bt_cmd_parser #(
   parameter logic [7:0]  HEADER  = 8'hAA,
   parameter logic [31:0] TIMEOUT = 32'd160000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] cmd,
   output logic [7:0] arg,
   output logic       cmd_valid,
   output logic       chk_err,
   output logic       tmo_err,
   output logic [7:0] err_count
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HDR     = 2'd1;
   localparam logic [1:0] ST_GOT_CMD = 2'd2;
   localparam logic [1:0] ST_GOT_ARG = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [7:0]  shadow_cmd_q, shadow_cmd_d;
   logic [7:0]  shadow_arg_q, shadow_arg_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  arg_q, arg_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        chk_err_q, chk_err_d;
   logic        tmo_err_q, tmo_err_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        expired;

   // A strobe on the expiry cycle takes precedence over the timeout.
   assign expired = (state_q != ST_IDLE) && !rx_valid && (timer_q == TIMEOUT - 32'd1);

   always_comb begin
      state_d      = state_q;
      shadow_cmd_d = shadow_cmd_q;
      shadow_arg_d = shadow_arg_q;
      cmd_d        = cmd_q;
      arg_d        = arg_q;
      cmd_valid_d  = 1'b0;
      chk_err_d    = 1'b0;
      tmo_err_d    = 1'b0;
      err_count_d  = err_count_q;

      if (state_q == ST_IDLE || rx_valid) begin
         timer_d = 32'd0;
      end else begin
         timer_d = timer_q + 32'd1;
      end

      if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_data == HEADER) begin
                  state_d = ST_HDR;
               end
            end
            ST_HDR: begin
               shadow_cmd_d = rx_data;
               state_d      = ST_GOT_CMD;
            end
            ST_GOT_CMD: begin
               shadow_arg_d = rx_data;
               state_d      = ST_GOT_ARG;
            end
            default: begin
               if (rx_data == (shadow_cmd_q ^ shadow_arg_q)) begin
                  cmd_d       = shadow_cmd_q;
                  arg_d       = shadow_arg_q;
                  cmd_valid_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         endcase
      end else if (expired) begin
         tmo_err_d = 1'b1;
         state_d   = ST_IDLE;
         timer_d   = 32'd0;
      end

      if ((chk_err_d || tmo_err_d) && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shadow_cmd_q <= 8'd0;
         shadow_arg_q <= 8'd0;
         timer_q      <= 32'd0;
         cmd_q        <= 8'd0;
         arg_q        <= 8'd0;
         cmd_valid_q  <= 1'b0;
         chk_err_q    <= 1'b0;
         tmo_err_q    <= 1'b0;
         err_count_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         shadow_cmd_q <= shadow_cmd_d;
         shadow_arg_q <= shadow_arg_d;
         timer_q      <= timer_d;
         cmd_q        <= cmd_d;
         arg_q        <= arg_d;
         cmd_valid_q  <= cmd_valid_d;
         chk_err_q    <= chk_err_d;
         tmo_err_q    <= tmo_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign cmd       = cmd_q;
   assign arg       = arg_q;
   assign cmd_valid = cmd_valid_q;
   assign chk_err   = chk_err_q;
   assign tmo_err   = tmo_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Scoreboard bench for bt_cmd_parser: stimulus pushes expected events, a
// negedge monitor pops and compares whenever a status pulse appears.
module tb_bt_cmd_parser;

   localparam logic [31:0] TMO = 32'd200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic [7:0] cmd, arg, err_count;
   logic       cmd_valid, chk_err, tmo_err;

   typedef struct packed {
      logic [1:0] kind;   // 1 = cmd_valid, 2 = chk_err, 3 = tmo_err
      logic [7:0] cmd;
      logic [7:0] arg;
      logic [7:0] errc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic [7:0] m_cmd = 8'd0, m_arg = 8'd0, m_err = 8'd0;

   bt_cmd_parser #(.HEADER(8'hAA), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd(cmd), .arg(arg), .cmd_valid(cmd_valid), .chk_err(chk_err),
      .tmo_err(tmo_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] c, input logic [7:0] a);
      exp_t e;
      if (kind == 2'd1) begin
         m_cmd = c;
         m_arg = a;
      end else if (m_err != 8'hFF) begin
         m_err = m_err + 8'd1;
      end
      e.kind = kind;
      e.cmd  = m_cmd;
      e.arg  = m_arg;
      e.errc = m_err;
      exp_q.push_back(e);
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
      if (k == (c ^ a)) push(2'd1, c, a);
      else              push(2'd2, 8'd0, 8'd0);
      send(8'hAA); send(c); send(a); send(k);
   endtask

   task automatic check_static(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, req);
      end else begin
         $display("ok   %s: %02h", name, act);
      end
   endtask

   // Monitor: one pop per status pulse, decoupled from stimulus.
   always @(negedge clk) begin
      if (!rst && (cmd_valid || chk_err || tmo_err)) begin
         logic [1:0] kind;
         exp_t e;
         kind = cmd_valid ? 2'd1 : (chk_err ? 2'd2 : 2'd3);
         checks++;
         if ((32'(cmd_valid) + 32'(chk_err) + 32'(tmo_err)) != 32'd1) begin
            errors++;
            $display("FAIL exclusive: got v=%0b c=%0b t=%0b expected one pulse", cmd_valid, chk_err, tmo_err);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d expected none", kind);
         end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.cmd !== cmd || e.arg !== arg || e.errc !== err_count) begin
               errors++;
               $display("FAIL event: got kind=%0d cmd=%02h arg=%02h err=%02h expected kind=%0d cmd=%02h arg=%02h err=%02h",
                        kind, cmd, arg, err_count, e.kind, e.cmd, e.arg, e.errc);
            end else begin
               $display("ok   event kind=%0d cmd=%02h arg=%02h err=%02h", kind, cmd, arg, err_count);
            end
         end
      end
   end

   initial begin
      idle(3);
      check_static("reset_cmd", cmd, 8'h00);
      check_static("reset_err", err_count, 8'h00);
      check_static("reset_pulses", {5'd0, cmd_valid, chk_err, tmo_err}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // 1: good frame; 2: bad checksum keeps old cmd/arg
      frame(8'h12, 8'h34, 8'h26);
      idle(2);
      frame(8'h12, 8'h34, 8'h27);
      idle(2);
      check_static("hold_cmd_after_chk", cmd, 8'h12);

      // 3: timeout after AA 05, then fresh frame
      push(2'd3, 8'd0, 8'd0);
      send(8'hAA); send(8'h05);
      idle(int'(TMO) + 2);
      frame(8'h01, 8'h02, 8'h03);
      idle(2);

      // 4: garbage ignored, header value treated as data mid-frame
      send(8'h55); send(8'h00);
      frame(8'hAA, 8'hAA, 8'hAA);
      idle(2);

      // 5: strobe on the exact expiry cycle keeps the frame alive
      push(2'd1, 8'h5A, 8'hC3);
      send(8'hAA); send(8'h5A);
      idle(int'(TMO) - 1);
      send(8'hC3);
      idle(int'(TMO) - 1);
      send(8'h99);
      idle(2);
      check_static("after_expiry_cmd", cmd, 8'h5A);

      // 6: async reset mid-frame, then good frame, then saturate err_count
      send(8'hAA); send(8'h12); send(8'h34);
      #2 rst = 1'b1;
      #1;
      check_static("midreset_cmd", cmd, 8'h00);
      check_static("midreset_err", err_count, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      m_cmd = 8'd0; m_arg = 8'd0; m_err = 8'd0;
      exp_q.delete();
      idle(1);
      frame(8'h12, 8'h34, 8'h26);
      for (int i = 0; i < 260; i++) frame(8'h01, 8'h02, 8'h00);
      idle(4);
      check_static("sat_err", err_count, 8'hFF);
      check_static("sat_cmd", cmd, 8'h12);
      check_static("queue_drained", 8'(exp_q.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
